// File: rtl/ibex_rf_wr_ctrl_if.sv
// ibex_rf_wr_ctrl_if
// Core-to-controller write handshake bundle.
//   wr_req   : core write request (valid), driven by the core
//   wr_addr  : core write address (5 bits)
//   wr_data  : core write data (DataWidth bits)
//   wr_ready : controller accepts core writes this cycle
// Modports: master = writeback stage (core side), slave = write controller.
interface ibex_rf_wr_ctrl_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 wr_req;
    logic [4:0]           wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 wr_ready;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ibex_rf_wr_ctrl.sv
// ibex_rf_wr_ctrl
// Write-side controller for the FPGA register file. It owns the single write
// port, sweeps x1..xLAST to WordZeroVal after reset and on scrub request
// (the RAM primitives power up uninitialised), and otherwise forwards core
// writebacks combinationally. Writes to x0 are dropped silently; writes to
// illegal addresses (bit 4 set in RV32E) are dropped and flagged on err_o.
// Ports:
//   clk_i        : sole clock, rising edge
//   rst_i        : synchronous active-high reset
//   wr_if        : core write handshake (slave side: req/addr/data in, ready out)
//   scrub_req_i  : single-cycle pulse requesting a re-sweep
//   rf_we_o      : register file write enable
//   rf_waddr_o   : register file write address
//   rf_wdata_o   : register file write data
//   init_done_o  : high when no sweep is in progress
//   err_o        : one-cycle pulse, the cycle after an illegal accepted write
module ibex_rf_wr_ctrl #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_rf_wr_ctrl_if.slave     wr_if,
    input  logic                 scrub_req_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 init_done_o,
    output logic                 err_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

    typedef enum logic {
        SWEEP,
        RUN
    } state_e;

    state_e     r_state;
    state_e     w_stateNext;
    logic [4:0] r_cnt;
    logic [4:0] w_cntNext;
    logic       r_err;
    logic       w_errNext;
    logic       w_addrLegal;
    logic       w_ready;

    // In RV32E only x0..x15 exist, so any address with bit 4 set is illegal.
    assign w_addrLegal = RV32E ? ~wr_if.wr_addr[4] : 1'b1;

    // State, sweep counter and error flop. The counter starts at 1 because
    // x0 is hardwired and never needs sweeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SWEEP;
            r_cnt   <= 5'd1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_err   <= w_errNext;
        end
    end

    // Next-state and output decode. While reset is held every output is
    // forced to its idle value, independent of the (possibly stale) state.
    // A scrub in RUN still lets the same-cycle core write through before
    // the sweep starts; a scrub during SWEEP is simply not looked at.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_errNext   = 1'b0;
        w_ready     = 1'b0;
        rf_we_o     = 1'b0;
        rf_waddr_o  = 5'd0;
        rf_wdata_o  = WordZeroVal;
        init_done_o = 1'b0;
        err_o       = 1'b0;

        if (!rst_i) begin
            err_o = r_err;
            case (r_state)
                SWEEP: begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = r_cnt;
                    w_cntNext  = r_cnt + 5'd1;
                    if (r_cnt == LastAddr) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    w_ready     = 1'b1;
                    init_done_o = 1'b1;
                    rf_waddr_o  = wr_if.wr_addr;
                    rf_wdata_o  = wr_if.wr_data;
                    rf_we_o     = wr_if.wr_req && (wr_if.wr_addr != 5'd0) && w_addrLegal;
                    w_errNext   = wr_if.wr_req && !w_addrLegal;
                    if (scrub_req_i) begin
                        w_stateNext = SWEEP;
                        w_cntNext   = 5'd1;
                    end
                end
                default: begin
                    w_stateNext = SWEEP;
                    w_cntNext   = 5'd1;
                end
            endcase
        end
    end

    assign wr_if.wr_ready = w_ready;

endmodule

// File: tb/tb_ibex_rf_wr_ctrl.sv
// tb_ibex_rf_wr_ctrl
// Drives an RV32 and an RV32E instance with identical stimulus and compares
// every output each cycle against a behavioural model that tracks "cycles
// since the sweep began" and a reference register-file image. A small
// register file in the bench captures the DUT write port so memory contents
// can be compared against the model image.
module tb_ibex_rf_wr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic scrub;

    ibex_rf_wr_ctrl_if #(.DataWidth(32)) busA ();
    ibex_rf_wr_ctrl_if #(.DataWidth(32)) busE ();

    logic        weA, weE, doneA, doneE, errA, errE;
    logic [4:0]  waddrA, waddrE;
    logic [31:0] wdataA, wdataE;

    ibex_rf_wr_ctrl #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0)) dutA (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_if       (busA.slave),
        .scrub_req_i (scrub),
        .rf_we_o     (weA),
        .rf_waddr_o  (waddrA),
        .rf_wdata_o  (wdataA),
        .init_done_o (doneA),
        .err_o       (errA)
    );

    ibex_rf_wr_ctrl #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0)) dutE (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_if       (busE.slave),
        .scrub_req_i (scrub),
        .rf_we_o     (weE),
        .rf_waddr_o  (waddrE),
        .rf_wdata_o  (wdataE),
        .init_done_o (doneE),
        .err_o       (errE)
    );

    int checks   = 0;
    int failures = 0;

    // Model state per configuration (0 = RV32, 1 = RV32E).
    int          sweepAge [2];
    logic        errPend  [2];
    logic [31:0] memModel [2][32];
    logic [31:0] rfMem    [2][32];

    // Bench-side register file fed by each DUT's write port.
    always @(posedge clk) begin
        if (weA) rfMem[0][waddrA] <= wdataA;
        if (weE) rfMem[1][waddrE] <= wdataE;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic checkMemory();
        for (int c = 0; c < 2; c++) begin
            int last;
            last = (c == 1) ? 15 : 31;
            for (int a = 1; a <= last; a++) begin
                checkOutput($sformatf("mem%0d_x%0d", c, a), {32'h0, rfMem[c][a]}, {32'h0, memModel[c][a]});
            end
        end
    endtask

    // One clock cycle: drive inputs after the edge, compare mid-cycle
    // against the model, then advance the model to the next cycle.
    task automatic applyStimulus(input logic r, input logic req, input logic [4:0] addr,
                                 input logic [31:0] data, input logic s, input bit memCheck);
        @(posedge clk);
        #1;
        if (memCheck) checkMemory();
        rst = r;
        scrub = s;
        busA.wr_req = req;  busA.wr_addr = addr;  busA.wr_data = data;
        busE.wr_req = req;  busE.wr_addr = addr;  busE.wr_data = data;
        #3;
        for (int c = 0; c < 2; c++) begin
            int          last;
            logic        eWe, eReady, eDone, eErr, legal;
            logic [4:0]  eAddr;
            logic [31:0] eData;
            logic        aWe, aReady, aDone, aErr;
            logic [4:0]  aAddr;
            logic [31:0] aData;
            last   = (c == 1) ? 15 : 31;
            legal  = (c == 1) ? (addr < 5'd16) : 1'b1;
            aWe    = (c == 0) ? weA : weE;
            aReady = (c == 0) ? busA.wr_ready : busE.wr_ready;
            aDone  = (c == 0) ? doneA : doneE;
            aErr   = (c == 0) ? errA : errE;
            aAddr  = (c == 0) ? waddrA : waddrE;
            aData  = (c == 0) ? wdataA : wdataE;

            if (r) begin
                eWe = 1'b0; eReady = 1'b0; eDone = 1'b0; eErr = 1'b0;
                eAddr = 5'd0; eData = 32'h0;
            end else if (sweepAge[c] < last) begin
                eWe = 1'b1; eReady = 1'b0; eDone = 1'b0; eErr = errPend[c];
                eAddr = 5'(sweepAge[c] + 1); eData = 32'h0;
            end else begin
                eReady = 1'b1; eDone = 1'b1; eErr = errPend[c];
                eWe = req && (addr != 5'd0) && legal;
                eAddr = addr; eData = data;
            end

            checkOutput($sformatf("we%0d", c),    {63'h0, aWe},    {63'h0, eWe});
            checkOutput($sformatf("ready%0d", c), {63'h0, aReady}, {63'h0, eReady});
            checkOutput($sformatf("done%0d", c),  {63'h0, aDone},  {63'h0, eDone});
            checkOutput($sformatf("err%0d", c),   {63'h0, aErr},   {63'h0, eErr});
            checkOutput($sformatf("waddr%0d", c), {59'h0, aAddr},  {59'h0, eAddr});
            checkOutput($sformatf("wdata%0d", c), {32'h0, aData},  {32'h0, eData});

            if (r) begin
                sweepAge[c] = 0;
                errPend[c]  = 1'b0;
            end else if (sweepAge[c] < last) begin
                memModel[c][sweepAge[c] + 1] = 32'h0;
                sweepAge[c] = sweepAge[c] + 1;
                errPend[c]  = 1'b0;
            end else begin
                if (eWe) memModel[c][addr] = data;
                errPend[c] = req && !legal;
                if (s) sweepAge[c] = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        scrub = 1'b0;
        busA.wr_req = 1'b0;  busA.wr_addr = 5'd0;  busA.wr_data = 32'h0;
        busE.wr_req = 1'b0;  busE.wr_addr = 5'd0;  busE.wr_data = 32'h0;
        for (int c = 0; c < 2; c++) begin
            sweepAge[c] = 0;
            errPend[c]  = 1'b0;
        end

        // Reset release and full sweep.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(35);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Core writes: legal x5, x0 drop, x17 (illegal in RV32E), x16.
        applyStimulus(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd0,  32'h11111111, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 5'd17, 32'h22222222, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd16, 32'h33333333, 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Request held across the whole sweep after a reset.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h00001234, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) applyStimulus(1'b0, 1'b1, 5'd3, 32'h00001234, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Scrub with a same-cycle write, then a second scrub mid-sweep.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        idle(35);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Reset mid-sweep at sweep cycle 10 for two cycles.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(10);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        idle(35);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic with occasional scrubs and resets.
        for (int i = 0; i < 400; i++) begin
            logic        r, q, s;
            logic [4:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 29) == 0);
            q = $urandom_range(0, 1) == 1;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            applyStimulus(r, q, a, d, s, (i % 50) == 49);
        end
        idle(35);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
